port_uart_bridge: RTL

Serial peripheral attached to the core's 8-bit OUTPORT/INPORT pair. The core writes a byte to OUTPORT; this block detects the new value and serialises it as an 8N1 UART frame on uart_tx. It deserialises 8N1 frames arriving on uart_rx and presents each received byte on INPORT, where the core reads it. It is the peripheral end of the core's port interface and runs in the core clock domain.

---
 rtl/port_uart_bridge.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/port_uart_bridge.sv
// Port-mapped 8N1 UART bridge: changes on the core's OUTPORT are serialised on uart_tx,
// frames arriving on uart_rx are deserialised and presented on INPORT.
module port_uart_bridge #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  IDLE_OUT     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] outport,
  output logic [7:0] inport,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       tx_busy,
  output logic       tx_drop,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int unsigned      CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------- transmit
  tx_state_t        tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]       tx_idx, tx_idx_n;
  logic [7:0]       tx_data, tx_data_n;
  logic [7:0]       pend, pend_n;
  logic             pend_full, pend_full_n;
  logic [7:0]       prev_out, prev_out_n;
  logic             tx_drop_n, tx_line_n, tx_busy_n;
  logic             tx_req, tx_bit_end, tx_load, req_taken;
  logic [7:0]       tx_load_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_data   <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      prev_out  <= IDLE_OUT;
      uart_tx   <= 1'b1;
      tx_busy   <= 1'b0;
      tx_drop   <= 1'b0;
    end else begin
      tx_state  <= tx_state_n;
      tx_cnt    <= tx_cnt_n;
      tx_idx    <= tx_idx_n;
      tx_data   <= tx_data_n;
      pend      <= pend_n;
      pend_full <= pend_full_n;
      prev_out  <= prev_out_n;
      uart_tx   <= tx_line_n;
      tx_busy   <= tx_busy_n;
      tx_drop   <= tx_drop_n;
    end
  end

  always_comb begin
    tx_state_n   = tx_state;
    tx_cnt_n     = tx_cnt;
    tx_idx_n     = tx_idx;
    tx_data_n    = tx_data;
    pend_n       = pend;
    pend_full_n  = pend_full;
    tx_drop_n    = tx_drop;
    tx_line_n    = uart_tx;
    tx_load      = 1'b0;
    tx_load_byte = outport;
    req_taken    = 1'b0;
    tx_req       = (outport != prev_out);
    tx_bit_end   = (tx_cnt == BIT_LAST);
    prev_out_n   = tx_req ? outport : prev_out;

    case (tx_state)
      TX_IDLE: begin
        if (pend_full) begin
          tx_load      = 1'b1;
          tx_load_byte = pend;
          pend_full_n  = 1'b0;
        end else if (tx_req) begin
          tx_load   = 1'b1;
          req_taken = 1'b1;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
          tx_line_n  = tx_data[0];
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_line_n  = 1'b1;
          end else begin
            tx_idx_n  = tx_idx + 3'd1;
            tx_line_n = tx_data[tx_idx_n];
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      TX_STOP: begin
        // end of stop bit chains straight into the next frame when one is waiting
        if (tx_bit_end) begin
          if (pend_full) begin
            tx_load      = 1'b1;
            tx_load_byte = pend;
            pend_full_n  = 1'b0;
          end else if (tx_req) begin
            tx_load   = 1'b1;
            req_taken = 1'b1;
          end else begin
            tx_state_n = TX_IDLE;
            tx_line_n  = 1'b1;
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase

    if (tx_load) begin
      tx_state_n = TX_START;
      tx_cnt_n   = '0;
      tx_idx_n   = '0;
      tx_data_n  = tx_load_byte;
      tx_line_n  = 1'b0;
    end

    // a request not started this edge parks in the single-entry buffer
    if (tx_req && !req_taken) begin
      if (pend_full_n) tx_drop_n = 1'b1;
      pend_n      = outport;
      pend_full_n = 1'b1;
    end

    tx_busy_n = (tx_state_n != TX_IDLE);
  end

  // ----------------------------------------------------------------- receive
  logic             rx_meta, rx_s;
  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_idx, rx_idx_n;
  logic [7:0]       rx_byte, rx_byte_n;
  logic [7:0]       inport_n;
  logic             rx_armed, rx_armed_n;
  logic             rx_valid_n, rx_ferr_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_byte  <= '0;
      rx_armed <= 1'b0;
      inport   <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_byte  <= rx_byte_n;
      rx_armed <= rx_armed_n;
      inport   <= inport_n;
      rx_valid <= rx_valid_n;
      rx_ferr  <= rx_ferr_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_byte_n  = rx_byte;
    rx_armed_n = rx_armed;
    inport_n   = inport;
    rx_valid_n = 1'b0;
    rx_ferr_n  = rx_ferr;

    case (rx_state)
      RX_IDLE: begin
        // only a high line seen while idle arms detection of the next start edge
        if (rx_s) begin
          rx_armed_n = 1'b1;
        end else if (rx_armed) begin
          rx_state_n = RX_START;
          rx_cnt_n   = '0;
          rx_armed_n = 1'b0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          if (rx_s) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_DATA;
            rx_cnt_n   = '0;
            rx_idx_n   = '0;
          end
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n  = '0;
          rx_byte_n = {rx_s, rx_byte[7:1]};
          if (rx_idx == 3'd7) rx_state_n = RX_STOP;
          else                rx_idx_n   = rx_idx + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_n = RX_IDLE;
          if (rx_s) begin
            inport_n   = rx_byte;
            rx_valid_n = 1'b1;
          end else begin
            rx_ferr_n = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule
